// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and helpers for the UART transmit/receive path
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Turns the XOR-reduction of a word into the parity bit for the given mode.
    function automatic logic parity_bit(input parity_t mode, input logic xor_red);
        return (mode == PAR_ODD) ? ~xor_red : xor_red;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : show-ahead synchronous FIFO with occupancy, shared by TX and RX
// Revision  : 1.0
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W + 1)'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_rd_ok;
    logic               w_wr_ok;

    // A write into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign w_rd_ok = i_rd && !o_empty;
    assign w_wr_ok = i_wr && (!o_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_level = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// uart_tx_frame : FIFO-buffered UART transmitter, configurable frame format
// Revision      : 1.0
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      OVERSAMPLE = 16,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                          mclkx16,
    input  logic                          reset,
    input  logic                          write,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          txrdy,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);
    localparam int                 c_CNT_W     = $clog2(OVERSAMPLE);
    localparam int                 c_BIT_W     = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = (STOP_BITS == 2);
    localparam logic               c_PAR_EN    = (PARITY != PAR_NONE);

    tx_state_t              r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_BIT_W-1:0]     r_bitn;
    logic                   r_stopn;
    logic [DATA_BITS-1:0]   r_tsr;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_ovf;

    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_head;
    logic                   w_bit_end;
    logic                   w_frame_end;
    logic                   w_pop;
    logic                   w_head_par;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mclkx16),
        .rst_n   (reset),
        .i_wr    (write),
        .i_wdata (data),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_bit_end   = (r_cnt == c_CNT_LAST);
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_stopn == c_STOP_LAST);
    // Popping at the end of the last stop bit chains frames with no idle gap.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign w_head_par  = parity_bit(PARITY, ^w_head);

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (write && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_stopn <= 1'b0;
            r_tsr   <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_cnt <= w_bit_end ? '0 : r_cnt + c_CNT_W'(1);
            if (w_pop) begin
                r_tsr   <= w_head;
                r_par   <= w_head_par;
                r_state <= START;
                r_tx    <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tx  <= 1'b1;
                        r_cnt <= '0;
                    end
                    START: begin
                        if (w_bit_end) begin
                            r_state <= DATA;
                            r_tx    <= r_tsr[0];
                            r_bitn  <= '0;
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            r_tsr <= r_tsr >> 1;
                            if (r_bitn == c_BIT_LAST) begin
                                if (c_PAR_EN) begin
                                    r_state <= uart_pkg::PARITY;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                    r_stopn <= 1'b0;
                                end
                            end else begin
                                r_bitn <= r_bitn + c_BIT_W'(1);
                                r_tx   <= r_tsr[1];
                            end
                        end
                    end
                    uart_pkg::PARITY: begin
                        if (w_bit_end) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                            r_stopn <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (w_bit_end) begin
                            if (r_stopn == c_STOP_LAST) begin
                                r_state <= IDLE;
                                r_tx    <= 1'b1;
                            end else begin
                                r_stopn <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx       = r_tx;
    assign txrdy    = !w_full;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_frame : directed self-checking bench for uart_tx_frame
// Revision         : 1.0
// ============================================================================
module tb_uart_tx_frame;

    logic       mclkx16 = 1'b0;
    logic       reset   = 1'b0;

    logic       wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
    logic       clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0, clr3 = 1'b0;
    logic [7:0] d0 = '0;
    logic [6:0] d1 = '0;
    logic [6:0] d2 = '0;
    logic [7:0] d3 = '0;
    logic       tx0, tx1, tx2, tx3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       busy0, busy1, busy2, busy3;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;
    logic       ovf0, ovf1, ovf2, ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mclkx16 = ~mclkx16;

    uart_tx_frame u_def (
        .mclkx16(mclkx16), .reset(reset), .write(wr0), .data(d0), .ovf_clr(clr0),
        .tx(tx0), .txrdy(rdy0), .busy(busy0), .level(lvl0), .overflow(ovf0)
    );

    uart_tx_frame #(.DATA_BITS(7), .PARITY(uart_pkg::PAR_EVEN)) u_even (
        .mclkx16(mclkx16), .reset(reset), .write(wr1), .data(d1), .ovf_clr(clr1),
        .tx(tx1), .txrdy(rdy1), .busy(busy1), .level(lvl1), .overflow(ovf1)
    );

    uart_tx_frame #(.DATA_BITS(7), .PARITY(uart_pkg::PAR_ODD)) u_odd (
        .mclkx16(mclkx16), .reset(reset), .write(wr2), .data(d2), .ovf_clr(clr2),
        .tx(tx2), .txrdy(rdy2), .busy(busy2), .level(lvl2), .overflow(ovf2)
    );

    uart_tx_frame #(.STOP_BITS(2), .OVERSAMPLE(8)) u_s2 (
        .mclkx16(mclkx16), .reset(reset), .write(wr3), .data(d3), .ovf_clr(clr3),
        .tx(tx3), .txrdy(rdy3), .busy(busy3), .level(lvl3), .overflow(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclkx16);
        #1;
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            2:       return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            2:       return busy2;
            default: return busy3;
        endcase
    endfunction

    task automatic do_write(input int sel, input logic [8:0] v);
        case (sel)
            0:       begin wr0 = 1'b1; d0 = v[7:0]; end
            1:       begin wr1 = 1'b1; d1 = v[6:0]; end
            2:       begin wr2 = 1'b1; d2 = v[6:0]; end
            default: begin wr3 = 1'b1; d3 = v[7:0]; end
        endcase
        tick();
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
    endtask

    // Entered just after the edge that drives the start bit; returns on the edge ending the frame.
    task automatic run_frame(input int sel, input int nbits, input int os,
                             input logic [15:0] pattern, input string tag);
        for (int k = 0; k < nbits; k++) begin
            repeat (os / 2) tick();
            check($sformatf("%s_bit%0d", tag, k), get_tx(sel), pattern[k]);
            if (k == nbits - 1) begin
                repeat (os / 2 - 1) tick();
                check($sformatf("%s_busy_last", tag), get_busy(sel), 1);
                tick();
            end else begin
                repeat (os / 2) tick();
            end
        end
    endtask

    task automatic wait_idle(input int sel, input int budget, input string tag);
        for (int i = 0; i < budget && get_busy(sel); i++) tick();
        check(tag, get_busy(sel), 0);
    endtask

    int lows;

    initial begin
        repeat (3) @(posedge mclkx16);
        #1;
        check("rst_tx", tx0, 1);
        check("rst_txrdy", rdy0, 1);
        check("rst_busy", busy0, 0);
        check("rst_level", lvl0, 0);
        check("rst_ovf", ovf0, 0);
        @(negedge mclkx16);
        reset = 1'b1;
        tick();

        // Default 8N1 frame of 8'h0F.
        do_write(0, 9'h00F);
        check("w0f_level", lvl0, 1);
        check("w0f_busy", busy0, 1);
        check("w0f_tx_idle", tx0, 1);
        tick();
        check("w0f_level_popped", lvl0, 0);
        run_frame(0, 10, 16, {6'b0, 1'b1, 8'h0F, 1'b0}, "w0f");
        check("w0f_busy_end", busy0, 0);

        // 7-bit even / odd parity frames of 7'h07.
        do_write(1, 9'h007);
        tick();
        run_frame(1, 10, 16, {6'b0, 1'b1, 1'b1, 7'h07, 1'b0}, "even");
        check("even_busy_end", busy1, 0);
        do_write(2, 9'h007);
        tick();
        run_frame(2, 10, 16, {6'b0, 1'b1, 1'b0, 7'h07, 1'b0}, "odd");
        check("odd_busy_end", busy2, 0);

        // Two stop bits at 8x oversampling: 88-cycle frame.
        do_write(3, 9'h00F);
        tick();
        run_frame(3, 11, 8, {5'b0, 2'b11, 8'h0F, 1'b0}, "stop2");
        check("stop2_busy_end", busy3, 0);

        // FIFO fill, overflow, clear, set-wins-over-clear.
        wr0 = 1'b1;
        d0 = 8'h11; tick();
        d0 = 8'h22; tick();
        d0 = 8'h33; tick();
        d0 = 8'h44; tick();
        d0 = 8'h55; tick();
        check("fill_level", lvl0, 4);
        check("fill_txrdy", rdy0, 0);
        check("fill_ovf", ovf0, 0);
        d0 = 8'h66; tick();
        check("ovf_set", ovf0, 1);
        check("ovf_level", lvl0, 4);
        wr0 = 1'b0; clr0 = 1'b1; tick();
        check("ovf_clr", ovf0, 0);
        wr0 = 1'b1; tick();
        check("ovf_set_wins", ovf0, 1);
        wr0 = 1'b0; tick();
        check("ovf_clr2", ovf0, 0);
        clr0 = 1'b0;
        repeat (152) tick();
        check("full_before_pop", rdy0, 0);
        tick();
        check("txrdy_on_pop", rdy0, 1);
        check("level_on_pop", lvl0, 3);
        wait_idle(0, 1000, "drain_idle");

        // Back-to-back frames.
        do_write(0, 9'h0A5);
        do_write(0, 9'h03C);
        check("b2b_start1", tx0, 0);
        check("b2b_level", lvl0, 1);
        run_frame(0, 10, 16, {6'b0, 1'b1, 8'hA5, 1'b0}, "b2b_a5");
        check("b2b_no_gap", tx0, 0);
        check("b2b_level2", lvl0, 0);
        run_frame(0, 10, 16, {6'b0, 1'b1, 8'h3C, 1'b0}, "b2b_3c");
        check("b2b_busy_end", busy0, 0);

        // Asynchronous reset in the middle of data bit 3.
        do_write(0, 9'h0F0);
        do_write(0, 9'h011);
        check("mid_level", lvl0, 1);
        repeat (72) tick();
        check("mid_bit3_tx", tx0, 0);
        #2 reset = 1'b0;
        #1;
        check("arst_tx", tx0, 1);
        check("arst_level", lvl0, 0);
        check("arst_txrdy", rdy0, 1);
        check("arst_busy", busy0, 0);
        @(negedge mclkx16);
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx0 !== 1'b1) lows++;
        end
        check("post_rst_idle", lows, 0);
        check("post_rst_busy", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
